// File: rtl/fcpu_pkg.sv
// Shared definitions for the boot loader path.
//   loader_state_t : AXI write FSM states of serial_loader
//   AXI_*          : fixed AXI4 encodings used by single-beat 32-bit writes
package fcpu_pkg;

    typedef enum logic [2:0] {
        RX_LEN,
        RX_DATA,
        WR,
        RESP,
        FIN
    } loader_state_t;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/serial_loader_byte_packer.sv
// byte_packer: 8->32 little-endian word assembler.
//   clk, nrst  : clock, synchronous active-low reset
//   din, en    : byte and its accept strobe
//   idx        : index of the next byte within the current group (0..3)
//   word       : assembled word, valid only while word_valid is high
//   word_valid : high in the cycle the 4th byte is accepted
// The 4th byte is merged combinationally so the consumer can register the
// full word on the same edge that accepts the last byte.
module byte_packer (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  din,
    input  logic        en,
    output logic [1:0]  idx,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] acc;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            idx <= 2'd0;
            acc <= 24'd0;
        end else if (en) begin
            case (idx)
                2'd0:    acc[7:0]   <= din;
                2'd1:    acc[15:8]  <= din;
                2'd2:    acc[23:16] <= din;
                default: ;
            endcase
            idx <= idx + 2'd1;
        end
    end

    assign word_valid = en && (idx == 2'd3);
    assign word       = {din, acc};

endmodule

// File: rtl/serial_loader.sv
// serial_loader: byte stream to AXI4 write bridge for booting memory.
// Image format: 4-byte little-endian word count N, then N little-endian
// 32-bit words. Word k is written to BASE_ADDR + 4*k with one single-beat
// AXI4 write, one outstanding at a time; done pulses when the image ends.
//   clk, nrst             : clock, synchronous active-low reset
//   i_data/i_valid/i_ready: receive byte stream
//   m_aw*, m_w*, m_b*     : AXI4 write channels (no read side)
//   busy                  : low only when idle waiting for a new count
//   done                  : one-cycle pulse, image complete
//   err                   : sticky, any non-OKAY write response
module serial_loader
    import fcpu_pkg::*;
#(
    parameter int                ADDR_W    = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ID_W      = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    output logic              i_ready,
    output logic [ID_W-1:0]   m_awid,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic [1:0]        m_awburst,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    loader_state_t state;
    logic [31:0]   count;
    logic [31:0]   word_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   pk_word;
    logic          pk_valid;
    logic          byte_hs;
    logic          aw_fin;
    logic          w_fin;

    assign byte_hs = i_valid && i_ready;

    // A single packer serves both the count and the data words; i_ready is
    // only ever high in RX_LEN/RX_DATA so groups never straddle states.
    byte_packer u_packer (
        .clk        (clk),
        .nrst       (nrst),
        .din        (i_data),
        .en         (byte_hs),
        .idx        (byte_idx),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    // A channel counts as finished once its valid has dropped or is
    // handshaking this cycle; the valid register itself is the done flag.
    assign aw_fin = !m_awvalid || m_awready;
    assign w_fin  = !m_wvalid  || m_wready;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= RX_LEN;
            count     <= 32'd0;
            word_idx  <= 32'd0;
            m_awaddr  <= BASE_ADDR;
            m_wdata   <= 32'd0;
            i_ready   <= 1'b0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RX_LEN: begin
                    i_ready <= 1'b1;
                    if (pk_valid) begin
                        count    <= pk_word;
                        word_idx <= 32'd0;
                        m_awaddr <= BASE_ADDR;
                        if (pk_word == 32'd0) begin
                            state   <= FIN;
                            i_ready <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    i_ready <= 1'b1;
                    if (pk_valid) begin
                        m_wdata   <= pk_word;
                        i_ready   <= 1'b0;
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        state     <= WR;
                    end
                end
                WR: begin
                    if (m_awvalid && m_awready) m_awvalid <= 1'b0;
                    if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        m_bready <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (m_bvalid) begin
                        m_bready <= 1'b0;
                        if (m_bresp != AXI_RESP_OKAY) err <= 1'b1;
                        word_idx <= word_idx + 32'd1;
                        m_awaddr <= m_awaddr + ADDR_W'(4);
                        if (word_idx + 32'd1 == count) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state   <= RX_DATA;
                            i_ready <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state    <= RX_LEN;
                    i_ready  <= 1'b1;
                    word_idx <= 32'd0;
                    m_awaddr <= BASE_ADDR;
                end
                default: state <= RX_LEN;
            endcase
        end
    end

    assign busy      = !((state == RX_LEN) && (byte_idx == 2'd0));
    assign m_awid    = '0;
    assign m_awlen   = 8'd0;
    assign m_awsize  = AXI_SIZE_4B;
    assign m_awburst = AXI_BURST_INCR;
    assign m_wstrb   = 4'hF;
    assign m_wlast   = 1'b1;

endmodule
